// File: rtl/tdm_demux_1_to_2_pkg.sv
// Shared definitions for the 1-to-2 TDM demultiplexer.
//   DEFAULT_WIDTH : default bits per channel word
//   state_t       : controller state encoding (IDLE / COLLECT)
package tdm_demux_1_to_2_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Channel a slot is routed to: even slots to channel 0, odd to channel 1.
    function automatic logic slot_channel(input logic slot_lsb);
        return slot_lsb;
    endfunction

endpackage

// File: rtl/tdm_demux_1_to_2_shift_in_reg.sv
// MSB-first serial-in / parallel-out shift register for one channel.
//   CLK : clock
//   RST : synchronous active-high reset, clears Q
//   EN  : shift D in at the LSB end this cycle
//   CLR : discard the held word; combined with EN the new word starts with D
//   D   : serial data bit
//   Q   : parallel word, first bit shifted in ends up at bit WIDTH-1
module shift_in_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic             D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_r;

    // Shift register update; CLR+EN restarts the word with D as its first bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_r <= {WIDTH{1'b0}};
        end else if (CLR) begin
            q_r <= EN ? {{(WIDTH-1){1'b0}}, D} : {WIDTH{1'b0}};
        end else if (EN) begin
            q_r <= {q_r[WIDTH-2:0], D};
        end else begin
            q_r <= q_r;
        end
    end

    assign Q = q_r;

endmodule

// File: rtl/tdm_demux_1_to_2.sv
// 1-to-2 time-division demultiplexer. A serial stream with channel 0 and
// channel 1 bits interleaved is split into two WIDTH-bit words, MSB first.
// FRAME (qualified by DIN_VALID) marks slot 0 of a 2*WIDTH-slot frame.
//   CLK       : clock
//   RST       : synchronous active-high reset
//   DIN       : serial TDM data bit
//   DIN_VALID : DIN carries a bit this cycle
//   FRAME     : this valid bit is slot 0 of a new frame
//   SEL       : channel the next accepted bit is routed to
//   OUT0/OUT1 : last completed channel-0 / channel-1 words
//   OUT_VALID : one-cycle pulse when OUT0/OUT1 are updated
//   FRAME_ERR : one-cycle pulse when a frame is aborted by an early FRAME
module tdm_demux_1_to_2
    import tdm_demux_1_to_2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DIN,
    input  logic             DIN_VALID,
    input  logic             FRAME,
    output logic             SEL,
    output logic [WIDTH-1:0] OUT0,
    output logic [WIDTH-1:0] OUT1,
    output logic             OUT_VALID,
    output logic             FRAME_ERR
);

    localparam int              CW       = $clog2(2 * WIDTH);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(2 * WIDTH - 1);

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             sel_r, sel_s;
    logic             en0_s, en1_s, clr_s, done_s, abort_s;
    logic [WIDTH-1:0] q0_s, q1_s;
    logic [WIDTH-1:0] out0_r, out1_r;
    logic             out_valid_r, frame_err_r;

    // Next-state, slot counter and shift-enable decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        en0_s   = 1'b0;
        en1_s   = 1'b0;
        clr_s   = 1'b0;
        done_s  = 1'b0;
        abort_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (DIN_VALID && FRAME) begin
                    clr_s   = 1'b1;
                    en0_s   = 1'b1;
                    cnt_s   = CNT_ONE;
                    state_s = COLLECT;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (DIN_VALID && FRAME) begin
                    // Early FRAME: drop partial words, this bit is the new slot 0.
                    abort_s = 1'b1;
                    clr_s   = 1'b1;
                    en0_s   = 1'b1;
                    cnt_s   = CNT_ONE;
                end else if (DIN_VALID && (cnt_r == CNT_LAST)) begin
                    // Final slot is captured directly into OUT1, no shift needed.
                    done_s  = 1'b1;
                    cnt_s   = CNT_ZERO;
                    state_s = IDLE;
                end else if (DIN_VALID) begin
                    en0_s   = (slot_channel(cnt_r[0]) == 1'b0);
                    en1_s   = (slot_channel(cnt_r[0]) == 1'b1);
                    cnt_s   = cnt_r + CNT_ONE;
                end else begin
                    state_s = COLLECT;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        sel_s = (state_s == COLLECT) ? cnt_s[0] : 1'b0;
    end

    // Controller state, slot counter and routing select registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            sel_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            sel_r   <= sel_s;
        end
    end

    // Output words and completion / abort pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out0_r      <= {WIDTH{1'b0}};
            out1_r      <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            out_valid_r <= done_s;
            frame_err_r <= abort_s;
            if (done_s) begin
                out0_r <= q0_s;
                out1_r <= {q1_s[WIDTH-2:0], DIN};
            end else begin
                out0_r <= out0_r;
                out1_r <= out1_r;
            end
        end
    end

    shift_in_reg #(.WIDTH(WIDTH)) u_ch0 (
        .CLK (CLK),
        .RST (RST),
        .EN  (en0_s),
        .CLR (clr_s),
        .D   (DIN),
        .Q   (q0_s)
    );

    shift_in_reg #(.WIDTH(WIDTH)) u_ch1 (
        .CLK (CLK),
        .RST (RST),
        .EN  (en1_s),
        .CLR (clr_s),
        .D   (DIN),
        .Q   (q1_s)
    );

    assign SEL       = sel_r;
    assign OUT0      = out0_r;
    assign OUT1      = out1_r;
    assign OUT_VALID = out_valid_r;
    assign FRAME_ERR = frame_err_r;

endmodule

// File: tb/tb_tdm_demux_1_to_2.sv
// Scoreboard bench for tdm_demux_1_to_2 (WIDTH=8). The stimulus side pushes
// expected OUT_VALID / FRAME_ERR events; a monitor pops and compares them.
module tb_tdm_demux_1_to_2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       frame = 1'b0;
    logic       sel;
    logic [7:0] out0, out1;
    logic       out_valid, frame_err;

    typedef struct packed {
        logic       is_valid;   // 1: OUT_VALID event, 0: FRAME_ERR event
        logic [7:0] o0;
        logic [7:0] o1;
    } exp_t;

    exp_t sb[$];
    int   vt[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    // Bench reference model state.
    int         exp_cnt = 0;
    logic [7:0] sh0 = 8'h00, sh1 = 8'h00;
    logic [7:0] last0 = 8'h00, last1 = 8'h00;
    logic [7:0] cur0 = 8'h00, cur1 = 8'h00;

    tdm_demux_1_to_2 #(.WIDTH(8)) dut (
        .CLK       (clk),
        .RST       (rst),
        .DIN       (din),
        .DIN_VALID (din_valid),
        .FRAME     (frame),
        .SEL       (sel),
        .OUT0      (out0),
        .OUT1      (out1),
        .OUT_VALID (out_valid),
        .FRAME_ERR (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops scoreboard on each pulse, checks held outputs every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && frame_err) begin
                chk("pulse_overlap", 32'd1, 32'd0);
            end else if (out_valid || frame_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, out_valid, frame_err}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_kind", {31'd0, out_valid}, {31'd0, e.is_valid});
                    if (out_valid) begin
                        n_valid++;
                        vt.push_back(cyc);
                        cur0 = e.o0;
                        cur1 = e.o1;
                    end else begin
                        n_err++;
                    end
                end
            end
            chk("out0_hold", {24'd0, out0}, {24'd0, cur0});
            chk("out1_hold", {24'd0, out1}, {24'd0, cur1});
        end
    end

    // Drive one cycle of stimulus and advance the reference model.
    task automatic drive_bit(input logic b, input logic v, input logic f);
        @(negedge clk);
        chk("sel", {31'd0, sel}, {31'd0, exp_cnt[0]});
        din = b;
        din_valid = v;
        frame = f;
        if (v) begin
            if (f) begin
                if (exp_cnt != 0) sb.push_back({1'b0, last0, last1});
                sh0 = {7'd0, b};
                sh1 = 8'h00;
                exp_cnt = 1;
            end else if (exp_cnt != 0) begin
                if (exp_cnt[0]) sh1 = {sh1[6:0], b};
                else            sh0 = {sh0[6:0], b};
                if (exp_cnt == 15) begin
                    last0 = sh0;
                    last1 = sh1;
                    sb.push_back({1'b1, sh0, sh1});
                    exp_cnt = 0;
                end else begin
                    exp_cnt++;
                end
            end
        end
    endtask

    task automatic send_partial(input logic [7:0] w0, input logic [7:0] w1, input int n);
        for (int k = 0; k < n; k++) begin
            drive_bit(k[0] ? w1[7 - k/2] : w0[7 - k/2], 1'b1, k == 0);
        end
    endtask

    // Full frame; with gap=1 an invalid cycle (FRAME high, to be ignored)
    // follows every accepted bit except the last.
    task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1, input logic gap);
        for (int k = 0; k < 16; k++) begin
            drive_bit(k[0] ? w1[7 - k/2] : w0[7 - k/2], 1'b1, k == 0);
            if (gap && k < 15) drive_bit(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive_bit(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic v, input logic f);
        @(negedge clk);
        rst = 1'b1;
        din = 1'b1;
        din_valid = v;
        frame = f;
        @(negedge clk);
        rst = 1'b0;
        din_valid = 1'b0;
        frame = 1'b0;
        exp_cnt = 0;
        sh0 = 8'h00;
        sh1 = 8'h00;
    endtask

    initial begin
        do_reset(1'b0, 1'b0);
        chk("rst_out0", {24'd0, out0}, 32'd0);
        chk("rst_out1", {24'd0, out1}, 32'd0);
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_pulses", {30'd0, out_valid, frame_err}, 32'd0);
        mon_en = 1'b1;

        // Bits without FRAME are discarded, then reset at slot 9 of a frame.
        for (int k = 0; k < 10; k++) drive_bit(k[0], 1'b1, 1'b0);
        idle(2);
        chk("discard_out0", {24'd0, out0}, 32'd0);
        chk("discard_out1", {24'd0, out1}, 32'd0);
        send_partial(8'hA5, 8'h3C, 9);
        do_reset(1'b1, 1'b0);
        chk("midrst_sel", {31'd0, sel}, 32'd0);
        // Reset dominates a simultaneous FRAME start.
        do_reset(1'b1, 1'b1);
        chk("rst_dom_sel", {31'd0, sel}, 32'd0);
        idle(3);
        chk("midrst_out0", {24'd0, out0}, 32'd0);
        chk("midrst_out1", {24'd0, out1}, 32'd0);

        // Contiguous frame A5/3C.
        send_frame(8'hA5, 8'h3C, 1'b0);
        idle(3);
        chk("a5_out0", {24'd0, out0}, 32'h0000_00A5);
        chk("a5_out1", {24'd0, out1}, 32'h0000_003C);

        // Same frame with DIN_VALID low every other cycle.
        send_frame(8'hA5, 8'h3C, 1'b1);
        idle(3);
        chk("gap_out0", {24'd0, out0}, 32'h0000_00A5);
        chk("gap_out1", {24'd0, out1}, 32'h0000_003C);
        chk("gap_npulse", n_valid, 32'd2);

        // Back-to-back frames FF/00 then 12/34.
        send_frame(8'hFF, 8'h00, 1'b0);
        send_frame(8'h12, 8'h34, 1'b0);
        idle(3);
        chk("b2b_out0", {24'd0, out0}, 32'h0000_0012);
        chk("b2b_out1", {24'd0, out1}, 32'h0000_0034);
        if (vt.size() >= 4) chk("b2b_spacing", vt[3] - vt[2], 32'd16);
        else                chk("b2b_npulse", vt.size(), 32'd4);

        // Frame aborted at slot 6, then full frame 81/7E.
        send_partial(8'hC3, 8'h99, 6);
        send_frame(8'h81, 8'h7E, 1'b0);
        idle(5);
        chk("abort_out0", {24'd0, out0}, 32'h0000_0081);
        chk("abort_out1", {24'd0, out1}, 32'h0000_007E);
        chk("n_err", n_err, 32'd1);
        chk("n_valid", n_valid, 32'd5);
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
